// File: rtl/multi_ch_nco_clkgen.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators reprogrammed via a
// valid/ready config port. Define NCO_PHASE_OFFSET_EN to add cfg_phase (per-channel start phase).
module multi_ch_nco_clkgen #(
    parameter int unsigned NUM_CH   = 9,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_sync,
`ifdef NCO_PHASE_OFFSET_EN
    input  logic [ACC_W-1:0]  cfg_phase,
`endif
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked,
    output logic              cfg_err
);

    typedef enum logic [1:0] {StIdle, StApply, StSettle} state_e;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [ACC_W-1:0]  inc_q [NUM_CH];
    logic [ACC_W-1:0]  inc_d [NUM_CH];
    logic [ACC_W:0]    sum   [NUM_CH];
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [3:0]        cap_ch_q;
    logic [ACC_W-1:0]  cap_inc_q;
    logic              cap_sync_q;
    logic [ACC_W-1:0]  load_phase;

    logic              capture;
    logic              ch_bad;
    logic              ce_sel;

    assign ch_bad = 32'(cfg_ch) >= NUM_CH;

`ifdef NCO_PHASE_OFFSET_EN
    logic [ACC_W-1:0] cap_phase_q;
    assign load_phase = cap_phase_q;
`else
    assign load_phase = '0;
`endif

    // Locked and ready share one register: both are high exactly while idle.
    assign cfg_ready = rdy_q;
    assign locked    = rdy_q;
    assign cfg_err   = err_q;
    assign ce        = ce_q;

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            sum[c]     = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
            clk_out[c] = acc_q[c][ACC_W-1];
        end
    end

    always_comb begin
        ce_sel = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (cap_ch_q == 4'(c)) begin
                ce_sel = ce_q[c];
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            acc_d[c] = sum[c][ACC_W-1:0];
            inc_d[c] = inc_q[c];
            ce_d[c]  = sum[c][ACC_W];
            if (state_q == StApply) begin
                // All channels freeze for the apply cycle so a sync clear lines them up exactly.
                acc_d[c] = cap_sync_q ? '0 : acc_q[c];
                ce_d[c]  = 1'b0;
                if (cap_ch_q == 4'(c)) begin
                    inc_d[c] = cap_inc_q;
                    acc_d[c] = load_phase;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                rdy_d = 1'b1;
                if (cfg_valid && rdy_q) begin
                    if (ch_bad) begin
                        err_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                        rdy_d   = 1'b0;
                        state_d = StApply;
                    end
                end
            end
            StApply: begin
                cnt_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                if (cap_inc_q == '0) begin
                    state_d = StIdle;
                    rdy_d   = 1'b1;
                end else if (ce_sel) begin
                    if (cnt_q + 8'd1 == 8'(LOCK_CNT)) begin
                        state_d = StIdle;
                        rdy_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q    <= StIdle;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            ce_q       <= '0;
            cap_ch_q   <= '0;
            cap_inc_q  <= '0;
            cap_sync_q <= 1'b0;
`ifdef NCO_PHASE_OFFSET_EN
            cap_phase_q <= '0;
`endif
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
                inc_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
            if (capture) begin
                cap_ch_q   <= cfg_ch;
                cap_inc_q  <= cfg_inc;
                cap_sync_q <= cfg_sync;
`ifdef NCO_PHASE_OFFSET_EN
                cap_phase_q <= cfg_phase;
`endif
            end
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= acc_d[c];
                inc_q[c] <= inc_d[c];
            end
        end
    end

endmodule
